multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS-style datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, addi and j.
- Drives the 2-bit `aluop` consumed by the ALU-control decoder, plus all mux selects and write enables.
- Sits between the instruction register's opcode field and the shared PC/memory/regfile/ALU datapath.

---
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-style datapath.
// Define MCCTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   rdy;

`ifdef MCCTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_en     = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEMADR;
          (opcode == OP_RTYPE): state_d = S_EXEC;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_ADDI):  state_d = S_ADDIEX;
          (opcode == OP_J):     state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = rdy;
        state_d    = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        aluop      = 2'b10;
        pc_src     = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a path/table model.
// Define MCCTRL_MEM_WAIT_EN to also exercise memory wait states.
module tb_multicycle_control;

`ifdef MCCTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_src;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_src(pc_src), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] outs();
    return {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop,
            pc_src, instr_done, illegal_op};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Output table written straight from the state listing.
  function automatic logic [16:0] exp_out(input int st, input logic z,
                                          input logic rdy,
                                          input logic [5:0] op);
    logic pe, io, mr, mw, irw, rd, m2r, rw, sa, dn, il;
    logic [1:0] sb, ao, ps;
    {pe, io, mr, mw, irw, rd, m2r, rw, sa, dn, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1; irw = rdy; pe = rdy; sb = 2'b01; end
      1:  begin sb = 2'b11; il = !legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = rdy; end
      6:  begin sa = 1; ao = 2'b01; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 2'b10; ps = 2'b01; pe = z; dn = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; dn = 1; end
      11: begin ps = 2'b10; pe = 1; dn = 1; end
      default: ;
    endcase
    return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting at a negedge in FETCH; ends at a negedge.
  // zsel: 0/1 fixed zero, 2 random. wsel: 0 ready, 1 random, 2 MEMWR 3-low.
  task automatic run_instr(input logic [5:0] op, input int zsel,
                           input int wsel);
    int path[$];
    int idx, cyc, lowleft, mw_cyc, done_cnt, st;
    logic rdy;
    path = {0, 1};
    case (op)
      6'b100011: path = {path, 2, 3, 4};
      6'b101011: path = {path, 2, 5};
      6'b000000: path = {path, 6, 7};
      6'b000100: path = {path, 8};
      6'b001000: path = {path, 9, 10};
      6'b000010: path = {path, 11};
      default: ;
    endcase
    idx = 0; cyc = 0; mw_cyc = 0; done_cnt = 0;
    lowleft = (wsel == 2) ? 3 : 0;
    opcode = op;
    while (idx < path.size()) begin
      st = path[idx];
      zero = (zsel == 2) ? 1'($urandom_range(1)) : 1'(zsel);
      if (wsel == 2 && st == 5 && lowleft > 0) begin
        mem_ready = 1'b0;
        lowleft--;
      end else if (wsel == 1) begin
        mem_ready = ($urandom_range(3) != 0);
      end else begin
        mem_ready = 1'b1;
      end
      rdy = WAIT_EN ? mem_ready : 1'b1;
      #1;
      chk($sformatf("state op=%b step=%0d", op, idx), 32'(state), 32'(st));
      chk($sformatf("outs op=%b st=%0d", op, st), 32'(outs()),
          32'(exp_out(st, zero, rdy, op)));
      if (mem_write) mw_cyc++;
      if (instr_done) done_cnt++;
      if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
      cyc++;
      @(negedge clk);
      if (cyc > 200) begin
        chk("cycle_budget", 32'(cyc), 32'd200);
        break;
      end
    end
    chk($sformatf("done_count op=%b", op), 32'(done_cnt),
        legal(op) ? 32'd1 : 32'd0);
    if (wsel == 2 && op == 6'b101011)
      chk("memwr_hold", 32'(mw_cyc), WAIT_EN ? 32'd4 : 32'd1);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b001000, 6'b000010};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(outs()), 32'(exp_out(0, zero, 1'b1, opcode)));
    @(negedge clk);
    rst_n = 1'b1;

    // Enter EXEC of an R-type, then pull reset asynchronously.
    opcode = 6'b000000;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset_exec", 32'(state), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_outs", 32'({mem_read, ir_write, pc_en, aluop}),
        32'b11100);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b101011, 0, 2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(5)];
      run_instr(op, 2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
